// File: rtl/dram_line_fetch.sv
// dram_line_fetch: issues burst read commands for one display line at a time,
// throttled against free pixel-FIFO space, with a safe frame restart path.
module dram_line_fetch #(
   parameter int unsigned X_SIZE     = 1600,
   parameter int unsigned Y_SIZE     = 900,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned MAX_BURST  = 256,
   parameter int unsigned FIFO_DEPTH = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_start,
   input  logic        line_req,
   input  logic [11:0] fifo_level,
   input  logic        busy,
   output logic        kick,
   output logic [31:0] read_addr,
   output logic [31:0] read_num,
   output logic [11:0] line_idx,
   output logic        line_done,
   output logic        overrun
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE,
      DRAIN
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] addr_acc, addr_nxt;
   logic [31:0] remaining, rem_nxt;
   logic [11:0] fifo_q;
   logic        pending, pend_nxt;
   logic [11:0] idx_nxt;
   logic        ovr_nxt, kick_nxt, done_nxt;
   logic [31:0] raddr_nxt, rnum_nxt;
   logic [31:0] chunk, room;
   logic        last_line;

   // Burst size, free FIFO space (from the registered level) and end-of-frame test.
   always_comb begin
      chunk     = (remaining < MAX_BURST) ? remaining : MAX_BURST;
      room      = FIFO_DEPTH - {20'd0, fifo_q};
      last_line = ({20'd0, line_idx} + 32'd1) >= Y_SIZE;
   end

   // Next-state and next-output logic; frame_start overrides everything else.
   always_comb begin
      state_nxt = state;
      addr_nxt  = addr_acc;
      rem_nxt   = remaining;
      idx_nxt   = line_idx;
      pend_nxt  = pending;
      ovr_nxt   = overrun;
      kick_nxt  = 1'b0;
      done_nxt  = 1'b0;
      raddr_nxt = read_addr;
      rnum_nxt  = read_num;
      if (frame_start) begin
         idx_nxt  = '0;
         addr_nxt = BASE_ADDR;
         rem_nxt  = X_SIZE;
         pend_nxt = 1'b0;
         case (state)
            WAIT_ACK, WAIT_DONE, DRAIN: state_nxt = DRAIN;
            default:                    state_nxt = ISSUE;
         endcase
      end else begin
         if (line_req && state != IDLE) begin
            if (pending) ovr_nxt  = 1'b1;
            else         pend_nxt = 1'b1;
         end
         case (state)
            IDLE: begin
               if (line_req && !last_line) begin
                  idx_nxt   = line_idx + 12'd1;
                  rem_nxt   = X_SIZE;
                  state_nxt = ISSUE;
               end
            end
            ISSUE: begin
               if (!busy && room >= chunk) begin
                  kick_nxt  = 1'b1;
                  raddr_nxt = addr_acc;
                  rnum_nxt  = chunk;
                  addr_nxt  = addr_acc + (chunk << 2);
                  rem_nxt   = remaining - chunk;
                  state_nxt = WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (busy) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
               if (!busy) begin
                  if (remaining != '0) begin
                     state_nxt = ISSUE;
                  end else begin
                     // a line_req landing on the completion cycle counts as queued
                     done_nxt = 1'b1;
                     pend_nxt = 1'b0;
                     if ((pending || line_req) && !last_line) begin
                        idx_nxt   = line_idx + 12'd1;
                        rem_nxt   = X_SIZE;
                        state_nxt = ISSUE;
                     end else begin
                        state_nxt = IDLE;
                     end
                  end
               end
            end
            DRAIN: begin
               if (!busy) state_nxt = ISSUE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State, datapath and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         addr_acc  <= '0;
         remaining <= '0;
         pending   <= 1'b0;
         fifo_q    <= '0;
         kick      <= 1'b0;
         read_addr <= '0;
         read_num  <= '0;
         line_idx  <= '0;
         line_done <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_nxt;
         addr_acc  <= addr_nxt;
         remaining <= rem_nxt;
         pending   <= pend_nxt;
         fifo_q    <= fifo_level;
         kick      <= kick_nxt;
         read_addr <= raddr_nxt;
         read_num  <= rnum_nxt;
         line_idx  <= idx_nxt;
         line_done <= done_nxt;
         overrun   <= ovr_nxt;
      end
   end

endmodule

// File: tb/tb_dram_line_fetch.sv
// tb_dram_line_fetch: randomized bench with a transaction-level model of the
// expected burst stream, line count and overrun flag.
module tb_dram_line_fetch;
   localparam int unsigned X_SIZE     = 1600;
   localparam int unsigned Y_SIZE     = 900;
   localparam logic [31:0] BASE_ADDR  = 32'h0000_0000;
   localparam int unsigned MAX_BURST  = 256;
   localparam int unsigned FIFO_DEPTH = 4096;

   logic        clk, rst, frame_start, line_req;
   logic [11:0] fifo_level;
   logic        busy;
   logic        kick, line_done, overrun;
   logic [31:0] read_addr, read_num;
   logic [11:0] line_idx;

   logic        fifo_rand, manual, manual_busy, auto_busy;
   logic [11:0] fifo_set, rnd_fifo;
   int unsigned lat_cfg, blen_cfg, wait_c, bcnt;
   logic        rsp_pend;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] num;
   } burst_t;
   burst_t      exp_q[$];
   burst_t      mon_b;
   int unsigned idx_m, exp_done, done_cnt, kick_cnt;
   logic        pend_m, ovr_m;
   int unsigned n_cmp, n_bad;
   int unsigned k0, seen;

   assign fifo_level = fifo_rand ? rnd_fifo : fifo_set;
   assign busy       = manual ? manual_busy : auto_busy;

   dram_line_fetch #(
      .X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .BASE_ADDR(BASE_ADDR),
      .MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .line_req(line_req),
      .fifo_level(fifo_level), .busy(busy), .kick(kick), .read_addr(read_addr),
      .read_num(read_num), .line_idx(line_idx), .line_done(line_done), .overrun(overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Expected bursts of line n, straight from the line address formula.
   task automatic push_line(input int unsigned n);
      burst_t      b;
      int unsigned left;
      logic [31:0] a;
      a    = BASE_ADDR + 32'(n * X_SIZE * 4);
      left = X_SIZE;
      while (left > 0) begin
         b.num  = (left > MAX_BURST) ? MAX_BURST : left;
         b.addr = a;
         exp_q.push_back(b);
         a    = a + b.num * 4;
         left = left - b.num;
      end
      exp_done++;
   endtask

   task automatic model_line_req(input logic active);
      if (active && pend_m) begin
         ovr_m = 1'b1;
      end else begin
         if (active) pend_m = 1'b1;
         if (idx_m + 1 < Y_SIZE) begin
            idx_m++;
            push_line(idx_m);
         end
      end
   endtask

   task automatic pulse_lr();
      line_req = 1'b1;
      @(negedge clk);
      line_req = 1'b0;
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic abort_frame();
      @(negedge clk);
      #1;
      exp_done--;
      exp_q.delete();
      idx_m  = 0;
      pend_m = 1'b0;
      push_line(0);
      frame_start = 1'b1;
      @(negedge clk);
      #1;
      frame_start = 1'b0;
   endtask

   task automatic wait_kick(input string tag, input int unsigned budget);
      int unsigned t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (kick !== 1'b1 && t < budget);
      check_eq(tag, 32'(kick), 32'd1);
   endtask

   task automatic wait_line_done(input string tag, input int unsigned budget);
      int unsigned t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (line_done !== 1'b1 && t < budget);
      check_eq(tag, 32'(line_done), 32'd1);
   endtask

   task automatic wait_done(input string tag, input int unsigned budget);
      int unsigned t = 0;
      while (!(exp_q.size() == 0 && done_cnt == exp_done && busy === 1'b0 && !rsp_pend)
             && t < budget) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      check_eq({tag, "_bursts_left"}, 32'(exp_q.size()), 32'd0);
      check_eq({tag, "_line_done_cnt"}, done_cnt, exp_done);
      check_eq({tag, "_line_idx"}, 32'(line_idx), idx_m);
      check_eq({tag, "_overrun"}, 32'(overrun), 32'(ovr_m));
      pend_m = 1'b0;
   endtask

   // Kick monitor: every command must match the head of the expected stream.
   initial begin
      forever begin
         @(negedge clk);
         if (kick === 1'b1) begin
            kick_cnt++;
            if (exp_q.size() == 0) begin
               check_eq("unexpected_kick", 32'(kick), 32'd0);
            end else begin
               mon_b = exp_q.pop_front();
               check_eq("kick_addr", read_addr, mon_b.addr);
               check_eq("kick_num", read_num, mon_b.num);
            end
         end
         if (line_done === 1'b1) done_cnt++;
      end
   end

   // DRAM reader model: busy rises lat_cfg cycles after a kick, lasts blen_cfg cycles.
   initial begin
      auto_busy = 1'b0;
      rsp_pend  = 1'b0;
      wait_c    = 0;
      bcnt      = 0;
      forever begin
         @(negedge clk);
         if (manual) begin
            rsp_pend  = 1'b0;
            auto_busy = 1'b0;
         end else begin
            if (kick === 1'b1) begin
               rsp_pend = 1'b1;
               wait_c   = lat_cfg;
            end
            if (auto_busy) begin
               if (bcnt <= 1) auto_busy = 1'b0;
               else bcnt--;
            end else if (rsp_pend) begin
               if (wait_c <= 1) begin
                  auto_busy = 1'b1;
                  bcnt      = blen_cfg;
                  rsp_pend  = 1'b0;
               end else begin
                  wait_c--;
               end
            end
         end
      end
   end

   initial begin
      rnd_fifo = '0;
      forever begin
         @(negedge clk);
         rnd_fifo = 12'($urandom_range(0, 4095));
      end
   end

   initial begin
      n_cmp = 0; n_bad = 0; kick_cnt = 0; done_cnt = 0; exp_done = 0;
      idx_m = 0; pend_m = 1'b0; ovr_m = 1'b0;
      rst = 1'b0; frame_start = 1'b0; line_req = 1'b0;
      fifo_rand = 1'b0; fifo_set = '0; manual = 1'b0; manual_busy = 1'b0;
      lat_cfg = 3; blen_cfg = 2;

      repeat (3) @(negedge clk);
      check_eq("rst_kick", 32'(kick), 32'd0);
      check_eq("rst_read_addr", read_addr, 32'd0);
      check_eq("rst_read_num", read_num, 32'd0);
      check_eq("rst_line_idx", 32'(line_idx), 32'd0);
      check_eq("rst_line_done", 32'(line_done), 32'd0);
      check_eq("rst_overrun", 32'(overrun), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // first frame, line 0: seven bursts, kick on the second edge
      k0 = kick_cnt;
      push_line(0);
      pulse_fs();
      check_eq("fs_lat_edge1", 32'(kick), 32'd0);
      @(negedge clk);
      check_eq("fs_lat_edge2", 32'(kick), 32'd1);
      wait_done("line0", 400);
      check_eq("line0_kicks", kick_cnt - k0, 32'd7);

      // walk every remaining line of the frame, then one request too many
      lat_cfg = 1; blen_cfg = 1;
      for (int n = 1; n < int'(Y_SIZE); n++) begin
         model_line_req(1'b0);
         pulse_lr();
         wait_done("walk", 200);
      end
      k0 = kick_cnt;
      model_line_req(1'b0);
      pulse_lr();
      repeat (20) @(negedge clk);
      check_eq("past_last_kicks", kick_cnt, k0);
      check_eq("past_last_overrun", 32'(overrun), 32'd0);
      check_eq("past_last_idx", 32'(line_idx), Y_SIZE - 1);

      // FIFO throttling: 196 free words holds a 256-word burst
      lat_cfg = 2; blen_cfg = 2;
      fifo_set = 12'd3900;
      idx_m = 0;
      push_line(0);
      pulse_fs();
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (kick === 1'b1) seen++;
      end
      check_eq("throttle_hold", seen, 32'd0);
      fifo_set = 12'd3840;
      @(negedge clk);
      check_eq("throttle_edge1", 32'(kick), 32'd0);
      @(negedge clk);
      check_eq("throttle_edge2", 32'(kick), 32'd1);
      check_eq("throttle_num", read_num, 32'd256);
      wait_done("throttle", 400);
      fifo_set = '0;

      // two requests during a fetch: one queued, one lost
      model_line_req(1'b0);
      pulse_lr();
      wait_kick("q_first_kick", 50);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      model_line_req(1'b1);
      pulse_lr();
      repeat ($urandom_range(1, 4)) @(negedge clk);
      model_line_req(1'b1);
      pulse_lr();
      check_eq("overrun_set", 32'(overrun), 32'd1);
      wait_line_done("q_line_done", 400);
      @(negedge clk);
      check_eq("queued_line_kick", 32'(kick), 32'd1);
      wait_done("queued", 800);

      // frame restart while a read is in flight
      manual = 1'b1; manual_busy = 1'b0;
      model_line_req(1'b0);
      pulse_lr();
      wait_kick("fly_kick", 50);
      manual_busy = 1'b1;
      repeat (3) @(negedge clk);
      abort_frame();
      k0 = kick_cnt;
      repeat (8) @(negedge clk);
      check_eq("drain_no_kick", kick_cnt, k0);
      check_eq("drain_line_idx", 32'(line_idx), 32'd0);
      manual_busy = 1'b0;
      manual = 1'b0;
      wait_kick("restart_kick", 10);
      check_eq("restart_addr", read_addr, BASE_ADDR);
      wait_done("restart", 400);

      // randomized traffic
      for (int it = 0; it < 24; it++) begin
         lat_cfg   = $urandom_range(1, 4);
         blen_cfg  = $urandom_range(1, 4);
         fifo_rand = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0: begin
               model_line_req(1'b0);
               pulse_lr();
            end
            1: begin
               model_line_req(1'b0);
               pulse_lr();
               wait_kick("rnd_q_kick", 100);
               repeat ($urandom_range(0, 5)) @(negedge clk);
               model_line_req(1'b1);
               pulse_lr();
            end
            2: begin
               idx_m = 0;
               pend_m = 1'b0;
               push_line(0);
               pulse_fs();
            end
            default: begin
               model_line_req(1'b0);
               pulse_lr();
               wait_kick("rnd_abort_kick", 100);
               repeat ($urandom_range(0, 8)) @(negedge clk);
               abort_frame();
            end
         endcase
         wait_done("rnd", 1500);
      end
      fifo_rand = 1'b0;

      // reset while waiting for the reader to acknowledge
      lat_cfg = 4; blen_cfg = 2;
      idx_m = 0;
      push_line(0);
      pulse_fs();
      wait_kick("rst_fly_kick", 50);
      #1;
      rst = 1'b0;
      exp_q.delete();
      exp_done--;
      idx_m = 0;
      ovr_m = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_kick", 32'(kick), 32'd0);
      check_eq("mid_rst_read_addr", read_addr, 32'd0);
      check_eq("mid_rst_read_num", read_num, 32'd0);
      check_eq("mid_rst_overrun", 32'(overrun), 32'd0);
      check_eq("mid_rst_line_idx", 32'(line_idx), 32'd0);
      rst = 1'b1;
      k0 = kick_cnt;
      repeat (20) @(negedge clk);
      check_eq("post_rst_no_kick", kick_cnt, k0);
      push_line(0);
      pulse_fs();
      wait_done("post_rst", 400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
